// File: rtl/dmem_selfcheck_ctrl.sv
// Self-check sequencer: watches the IF stream for a halt, then scans data memory
// through the console port and compares each word against an expected-value ROM.
module dmem_selfcheck_ctrl #(
  parameter int ADDR_W     = 11,
  parameter int WORD_W     = 32,
  parameter int LOOP_LIMIT = 49,
  parameter int NOP_LIMIT  = 8,
  parameter int CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              nrst,
  input  logic              start_en,
  input  logic [31:0]       if_inst,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] con_addr,
  input  logic [WORD_W-1:0] con_out,
  output logic [ADDR_W-1:0] exp_addr,
  input  logic [WORD_W-1:0] exp_data,
  output logic              halted,
  output logic              scan_done,
  output logic              busy,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              fail_valid,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [WORD_W-1:0] fail_actual,
  output logic [WORD_W-1:0] fail_expected
);

  localparam int RUN_MAX = (LOOP_LIMIT > NOP_LIMIT) ? LOOP_LIMIT : NOP_LIMIT;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MONITOR,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [31:0]        r_lastInst;
  logic [RUN_W-1:0]   r_sameRun;
  logic [RUN_W-1:0]   r_nopRun;
  logic [ADDR_W-1:0]  r_conAddr;
  logic [ADDR_W-1:0]  r_cmpAddr;
  logic               r_cmpValid;
  logic               r_halted;
  logic               r_scanDone;
  logic               r_busy;
  logic [CNT_W-1:0]   r_cycleCnt;
  logic [CNT_W-1:0]   r_passCnt;
  logic [CNT_W-1:0]   r_failCnt;
  logic               r_failValid;
  logic [ADDR_W-1:0]  r_failAddr;
  logic [WORD_W-1:0]  r_failActual;
  logic [WORD_W-1:0]  r_failExpected;

  logic w_isNop;
  logic w_sameInst;
  logic w_halt;
  logic w_match;

  // Both the compressed (c.nop) and the base-ISA (addi x0,x0,0) encodings count as NOP.
  assign w_isNop    = (if_inst[15:0] == 16'h0001) || (if_inst == 32'h0000_0013);
  assign w_sameInst = (if_inst == r_lastInst);
  assign w_halt     = (r_sameRun == RUN_W'(LOOP_LIMIT)) || (r_nopRun == RUN_W'(NOP_LIMIT));
  assign w_match    = (con_out == exp_data);

  always_ff @(posedge CLK) begin
    if (!nrst) begin
      r_state        <= S_IDLE;
      r_lastInst     <= '0;
      r_sameRun      <= '0;
      r_nopRun       <= '0;
      r_conAddr      <= '0;
      r_cmpAddr      <= '0;
      r_cmpValid     <= 1'b0;
      r_halted       <= 1'b0;
      r_scanDone     <= 1'b0;
      r_busy         <= 1'b0;
      r_cycleCnt     <= '0;
      r_passCnt      <= '0;
      r_failCnt      <= '0;
      r_failValid    <= 1'b0;
      r_failAddr     <= '0;
      r_failActual   <= '0;
      r_failExpected <= '0;
    end else begin
      r_failValid <= 1'b0;
      r_cmpValid  <= 1'b0;

      // Compare stage: console and ROM data belong to the address issued last cycle.
      if (r_cmpValid) begin
        if (w_match) begin
          if (r_passCnt != CNT_MAX) r_passCnt <= r_passCnt + 1'b1;
        end else begin
          if (r_failCnt != CNT_MAX) r_failCnt <= r_failCnt + 1'b1;
          r_failValid <= 1'b1;
          if (r_failCnt == '0) begin
            r_failAddr     <= r_cmpAddr;
            r_failActual   <= con_out;
            r_failExpected <= exp_data;
          end
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start_en) begin
            r_state        <= S_MONITOR;
            r_busy         <= 1'b1;
            r_lastInst     <= '0;
            r_sameRun      <= '0;
            r_nopRun       <= '0;
            r_conAddr      <= '0;
            r_halted       <= 1'b0;
            r_scanDone     <= 1'b0;
            r_cycleCnt     <= '0;
            r_passCnt      <= '0;
            r_failCnt      <= '0;
            r_failAddr     <= '0;
            r_failActual   <= '0;
            r_failExpected <= '0;
          end
        end
        S_MONITOR: begin
          if (r_cycleCnt != CNT_MAX) r_cycleCnt <= r_cycleCnt + 1'b1;
          if (w_halt) begin
            r_halted  <= 1'b1;
            r_state   <= S_SCAN;
            r_conAddr <= '0;
          end else if (w_sameInst) begin
            r_sameRun <= r_sameRun + 1'b1;
            if (w_isNop) r_nopRun <= r_nopRun + 1'b1;
          end else begin
            r_lastInst <= if_inst;
            r_sameRun  <= '0;
            r_nopRun   <= '0;
          end
        end
        S_SCAN: begin
          r_cmpValid <= 1'b1;
          r_cmpAddr  <= r_conAddr;
          if (r_conAddr >= last_addr) begin
            r_state <= S_DRAIN;
          end else begin
            r_conAddr <= r_conAddr + 1'b1;
          end
        end
        S_DRAIN: begin
          r_state    <= S_DONE;
          r_scanDone <= 1'b1;
          r_busy     <= 1'b0;
        end
        S_DONE: begin
          if (!start_en) begin
            r_state   <= S_IDLE;
            r_conAddr <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign con_addr      = r_conAddr;
  assign exp_addr      = r_conAddr;
  assign halted        = r_halted;
  assign scan_done     = r_scanDone;
  assign busy          = r_busy;
  assign cycle_cnt     = r_cycleCnt;
  assign pass_cnt      = r_passCnt;
  assign fail_cnt      = r_failCnt;
  assign fail_valid    = r_failValid;
  assign fail_addr     = r_failAddr;
  assign fail_actual   = r_failActual;
  assign fail_expected = r_failExpected;

endmodule

// File: tb/tb_dmem_selfcheck_ctrl.sv
// Directed bench for dmem_selfcheck_ctrl: NOP/loop/compressed halts, pass and
// mismatch scans, single-word scan, mid-scan reset and re-arm behaviour.
module tb_dmem_selfcheck_ctrl;

  localparam int ADDR_W = 11;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 16;

  logic              CLK;
  logic              nrst;
  logic              start_en;
  logic [31:0]       if_inst;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] con_addr;
  logic [WORD_W-1:0] con_out;
  logic [ADDR_W-1:0] exp_addr;
  logic [WORD_W-1:0] exp_data;
  logic              halted;
  logic              scan_done;
  logic              busy;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [CNT_W-1:0]  pass_cnt;
  logic [CNT_W-1:0]  fail_cnt;
  logic              fail_valid;
  logic [ADDR_W-1:0] fail_addr;
  logic [WORD_W-1:0] fail_actual;
  logic [WORD_W-1:0] fail_expected;

  logic [WORD_W-1:0] memAct [0:2047];
  logic [WORD_W-1:0] memExp [0:2047];

  int checks;
  int errors;
  int failPulses;
  int nCycles;

  dmem_selfcheck_ctrl dut (
    .CLK          (CLK),
    .nrst         (nrst),
    .start_en     (start_en),
    .if_inst      (if_inst),
    .last_addr    (last_addr),
    .con_addr     (con_addr),
    .con_out      (con_out),
    .exp_addr     (exp_addr),
    .exp_data     (exp_data),
    .halted       (halted),
    .scan_done    (scan_done),
    .busy         (busy),
    .cycle_cnt    (cycle_cnt),
    .pass_cnt     (pass_cnt),
    .fail_cnt     (fail_cnt),
    .fail_valid   (fail_valid),
    .fail_addr    (fail_addr),
    .fail_actual  (fail_actual),
    .fail_expected(fail_expected)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous-read models of the data memory and the expected-value ROM.
  always @(posedge CLK) begin
    con_out  <= memAct[con_addr];
    exp_data <= memExp[exp_addr];
  end

  always @(negedge CLK) if (fail_valid) failPulses++;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic waitHalt(input int budget, output int n);
    n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
    checkOutput("halt_reached", {63'd0, halted}, 64'd1);
  endtask

  task automatic waitDone(input int budget, output int n);
    n = 0;
    while (!scan_done && n < budget) begin
      tick();
      n++;
    end
    checkOutput("done_reached", {63'd0, scan_done}, 64'd1);
  endtask

  task automatic applyStimulus(input logic [31:0] inst);
    start_en = 1'b1;
    if_inst  = inst;
    tick();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    failPulses = 0;
    nrst       = 1'b0;
    start_en   = 1'b0;
    if_inst    = 32'h0;
    last_addr  = 11'd9;
    for (int i = 0; i < 2048; i++) begin
      memAct[i] = 32'(i * 3 + 1);
      memExp[i] = 32'(i * 3 + 1);
    end
    tick();
    tick();
    checkOutput("rst_con_addr", 64'(con_addr), 64'd0);
    checkOutput("rst_flags", {60'd0, busy, halted, scan_done, fail_valid}, 64'd0);
    checkOutput("rst_counts", {16'd0, cycle_cnt, pass_cnt, fail_cnt}, 64'd0);
    nrst = 1'b1;
    tick();

    // NOP halt with an all-pass scan of words 0..9
    applyStimulus(32'h0);
    checkOutput("busy_rise", {63'd0, busy}, 64'd1);
    for (int k = 0; k < 5; k++) begin
      if_inst = 32'h100 + 32'(k);
      tick();
    end
    checkOutput("nop_no_early_halt", {63'd0, halted}, 64'd0);
    if_inst = 32'h0000_0013;
    waitHalt(40, nCycles);
    checkOutput("nop_halt_ticks", 64'(nCycles), 64'd10);
    checkOutput("nop_cycle_cnt", 64'(cycle_cnt), 64'd15);
    checkOutput("scan_start_addr", 64'(con_addr), 64'd0);
    failPulses = 0;
    tick();
    checkOutput("scan_next_addr", 64'(con_addr), 64'd1);
    checkOutput("exp_addr_track", 64'(exp_addr), 64'd1);
    waitDone(40, nCycles);
    checkOutput("pass_done_latency", 64'(nCycles + 1), 64'd11);
    checkOutput("pass_pass_cnt", 64'(pass_cnt), 64'd10);
    checkOutput("pass_fail_cnt", 64'(fail_cnt), 64'd0);
    checkOutput("pass_no_pulses", 64'(failPulses), 64'd0);
    checkOutput("done_con_addr", 64'(con_addr), 64'd9);
    checkOutput("done_cycle_hold", 64'(cycle_cnt), 64'd15);
    start_en = 1'b0;
    tick();
    checkOutput("idle_busy", {63'd0, busy}, 64'd0);
    checkOutput("idle_con_addr", 64'(con_addr), 64'd0);
    checkOutput("idle_keep_pass", 64'(pass_cnt), 64'd10);

    // Loop halt with two corrupted words
    memAct[3] = 32'hDEAD_BEEF;
    memExp[3] = 32'h0000_0005;
    memAct[7] = 32'hDEAD_BEEF;
    memExp[7] = 32'h0000_0005;
    applyStimulus(32'h0000_006F);
    checkOutput("arm_clears_pass", 64'(pass_cnt), 64'd0);
    checkOutput("arm_clears_cycle", 64'(cycle_cnt), 64'd0);
    waitHalt(80, nCycles);
    checkOutput("loop_halt_ticks", 64'(nCycles), 64'd51);
    checkOutput("loop_cycle_cnt", 64'(cycle_cnt), 64'd51);
    failPulses = 0;
    waitDone(40, nCycles);
    checkOutput("mm_done_latency", 64'(nCycles), 64'd11);
    tick();
    checkOutput("mm_pass_cnt", 64'(pass_cnt), 64'd8);
    checkOutput("mm_fail_cnt", 64'(fail_cnt), 64'd2);
    checkOutput("mm_pulses", 64'(failPulses), 64'd2);
    checkOutput("mm_fail_addr", 64'(fail_addr), 64'd3);
    checkOutput("mm_fail_actual", 64'(fail_actual), 64'hDEAD_BEEF);
    checkOutput("mm_fail_expected", 64'(fail_expected), 64'h5);
    start_en = 1'b0;
    tick();

    // Compressed NOPs with varying upper halves must not halt; then a single-word scan
    last_addr = 11'd0;
    applyStimulus(32'h0);
    for (int k = 0; k < 20; k++) begin
      if_inst = {16'(k + 1), 16'h0001};
      tick();
    end
    checkOutput("cnop_no_halt", {63'd0, halted}, 64'd0);
    if_inst = 32'h0001_0001;
    waitHalt(40, nCycles);
    checkOutput("cnop_halt_ticks", 64'(nCycles), 64'd10);
    checkOutput("cnop_cycle_cnt", 64'(cycle_cnt), 64'd30);
    waitDone(10, nCycles);
    checkOutput("single_done_latency", 64'(nCycles), 64'd2);
    checkOutput("single_counts", {32'd0, pass_cnt, fail_cnt}, {32'd0, 16'd1, 16'd0});
    checkOutput("single_con_addr", 64'(con_addr), 64'd0);
    start_en = 1'b0;
    tick();

    // Reset while the scan is issuing address 4
    last_addr = 11'd9;
    applyStimulus(32'h0000_006F);
    waitHalt(80, nCycles);
    for (int k = 0; k < 4; k++) tick();
    checkOutput("pre_rst_addr", 64'(con_addr), 64'd4);
    nrst     = 1'b0;
    start_en = 1'b0;
    tick();
    checkOutput("midrst_addrs", {42'd0, con_addr, exp_addr}, 64'd0);
    checkOutput("midrst_flags", {60'd0, busy, halted, scan_done, fail_valid}, 64'd0);
    checkOutput("midrst_counts", {16'd0, cycle_cnt, pass_cnt, fail_cnt}, 64'd0);
    checkOutput("midrst_fail_data", {fail_actual, fail_expected}, 64'd0);
    nrst = 1'b1;
    tick();
    checkOutput("post_rst_idle", {63'd0, busy}, 64'd0);

    // Re-arm a full run, drop start_en in DONE, then re-arm to clear
    applyStimulus(32'h0000_006F);
    waitHalt(80, nCycles);
    failPulses = 0;
    waitDone(40, nCycles);
    tick();
    checkOutput("rearm_counts", {32'd0, pass_cnt, fail_cnt}, {32'd0, 16'd8, 16'd2});
    start_en = 1'b0;
    tick();
    checkOutput("rearm_idle_fail_addr", 64'(fail_addr), 64'd3);
    checkOutput("rearm_idle_fail_cnt", 64'(fail_cnt), 64'd2);
    applyStimulus(32'h0);
    checkOutput("rearm_clear_fail_cnt", 64'(fail_cnt), 64'd0);
    checkOutput("rearm_clear_fail_addr", 64'(fail_addr), 64'd0);
    checkOutput("rearm_busy", {63'd0, busy}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_selfcheck_ctrl.md
# dmem_selfcheck_ctrl

Self-check sequencer for the core's data memory console port (`con_addr`/`con_out`). It monitors the IF-stage instruction stream to detect program completion, either a stuck loop or a run of NOPs. It then walks the data memory through the console port and compares each word against an expected-value ROM, reporting pass/fail counts and the first mismatch. It sits beside `core` at the top level, replacing bench-side result checking, so on-board runs can self-report.

## Interface
- `ADDR_W`, 11, console/ROM address width (`DATAMEM_BITS+1`)
- `WORD_W`, 32, data word width
- `LOOP_LIMIT`, 49, repeated-instruction count that declares halt
- `NOP_LIMIT`, 8, repeated-NOP count that declares halt
- `CNT_W`, 16, width of the cycle, pass and fail counters

- `CLK`  in  1  single clock, rising edge
- `nrst`  in  1  reset, synchronous, active-low
- `start_en`  in  1  arm request (level)
- `if_inst`  in  32  instruction currently in IF (`CORE.if_inst`)
- `last_addr`  in  ADDR_W  highest word address to check, inclusive
- `con_addr`  out  ADDR_W  console read address to the core
- `con_out`  in  WORD_W  console read data; valid 1 cycle after `con_addr`
- `exp_addr`  out  ADDR_W  expected-ROM address; always equal to `con_addr`
- `exp_data`  in  WORD_W  expected word; valid 1 cycle after `exp_addr`
- `halted`  out  1  halt detected (sticky until IDLE)
- `scan_done`  out  1  scan complete (sticky until IDLE)
- `busy`  out  1  state is MONITOR, SCAN or DRAIN
- `cycle_cnt`  out  CNT_W  MONITOR cycles until halt, saturating
- `pass_cnt`, `fail_cnt`  out  CNT_W  compare results, saturating
- `fail_valid`  out  1  one-cycle pulse for each mismatch
- `fail_addr`  out  ADDR_W  address of the first mismatch
- `fail_actual`, `fail_expected`  out  WORD_W  data of the first mismatch

## Operation
- States: IDLE, MONITOR, SCAN, DRAIN, DONE.
- IDLE → MONITOR when `start_en`=1.
  - On entry, clear all counters, flags, `last_inst` and the run counters.
- MONITOR halt detection, evaluated each cycle:
  - NOP means `if_inst[15:0]`==16'h0001 or `if_inst`==32'h00000013.
  - If `if_inst`==`last_inst` and NOP: `nop_run`++ and `same_run`++.
  - Else if `if_inst`==`last_inst`: `same_run`++.
  - Else: `last_inst`<=`if_inst` and both runs <=0.
  - Halt when the registered `same_run`==LOOP_LIMIT or `nop_run`==NOP_LIMIT. Then set `halted`, go to SCAN, and freeze `cycle_cnt`.
  - `cycle_cnt` increments on every MONITOR cycle, including the halt cycle.
- SCAN: drives `con_addr` from 0, incrementing by 1 per cycle.
  - After issuing `last_addr`, go to DRAIN.
  - If `last_addr`=0, SCAN lasts exactly 1 cycle.
- Compare stage, one cycle behind the issue stage:
  - A compare is valid in every cycle following an issue cycle.
  - Equal: `pass_cnt`++.
  - Unequal: `fail_cnt`++ and pulse `fail_valid`.
  - On the first mismatch only, capture `fail_addr` (the delayed address), `fail_actual` and `fail_expected`.
- DRAIN: performs the final compare, then goes to DONE and sets `scan_done`.
- DONE: holds all results. Goes to IDLE when `start_en`=0; results stay visible in IDLE until the next arm.
- `start_en` is ignored in MONITOR, SCAN and DRAIN; the only abort is `nrst`.
- Counters saturate at 2^CNT_W−1 and never wrap. Word compare is a full-width equality.

## Timing
- Reset (`nrst`=0 at a rising edge) sets:
  - state IDLE;
  - `con_addr`, `exp_addr`, all counters, `fail_*` and `last_inst` to 0;
  - `halted`, `scan_done`, `busy`, `fail_valid` to 0.
- Reset mid-SCAN aborts immediately, with no further compares.
- `busy` rises the cycle after `start_en` is sampled in IDLE.
- From the halt cycle, `scan_done` rises after exactly `last_addr`+2 cycles: `last_addr`+1 SCAN cycles, then 1 DRAIN cycle.
- `fail_valid` is registered and asserted in the cycle after the compare data arrive.
- `pass_cnt`+`fail_cnt` equals `last_addr`+1 at `scan_done`.
- `con_addr` holds `last_addr` during DRAIN and DONE, and returns to 0 in IDLE.

## Test plan
- Halt on NOP: arm, feed 5 distinct instructions, then 32'h00000013 repeated.
  - Required: `halted` rises when `nop_run`==8; `cycle_cnt` equals the MONITOR cycle count; `con_addr` starts at 0 on the next cycle.
- Halt on loop: feed 32'h0000006F (`jal x0,0`) constantly.
  - Required: halt when `same_run`==49; `nop_run` stays 0.
- Compressed NOP: feed 16'h0001 in the low half with varying upper halves.
  - Required: no halt, because the runs reset.
  - Then hold 32'h00010001 constant: halt via `nop_run`==8.
- All-pass scan: `last_addr`=9, with `con_out` and `exp_data` models identical.
  - Required: `pass_cnt`=10, `fail_cnt`=0, `scan_done` exactly 11 cycles after halt, `fail_valid` never asserted.
- Mismatches: `last_addr`=9, corrupt words 3 and 7 (actual 32'hDEADBEEF, expected 32'h00000005).
  - Required: `pass_cnt`=8, `fail_cnt`=2, two `fail_valid` pulses, `fail_addr`=3, `fail_actual`=32'hDEADBEEF, `fail_expected`=32'h00000005.
- Reset and re-arm:
  - Assert `nrst`=0 during SCAN at address 4: required, all outputs zero next cycle.
  - Re-arm a full run, then drop `start_en` in DONE: required, IDLE retains results until the next `start_en` clears them.
